// File: rtl/gray_counter_updown.sv
// Up/down counter with a registered Gray-code view and a binary shadow.
// Gray output changes one bit per step, so other clock domains can sample it safely.
module gray_counter_updown #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] MINV = '0;

    logic [WIDTH-1:0] nb;
    logic             nwrap;
    logic             nsat;

    // Next count plus the wrap/sat flags for this edge; load beats en.
    always_comb begin
        nb    = bin_out;
        nwrap = 1'b0;
        nsat  = sat;
        if (load) begin
            nb   = load_bin;
            nsat = 1'b0;
        end else if (en && up) begin
            if (bin_out == MAXV) begin
                if (WRAP) begin
                    nb    = MINV;
                    nwrap = 1'b1;
                    nsat  = 1'b0;
                end else begin
                    nsat = 1'b1;
                end
            end else begin
                nb   = bin_out + 1'b1;
                nsat = 1'b0;
            end
        end else if (en) begin
            if (bin_out == MINV) begin
                if (WRAP) begin
                    nb    = MAXV;
                    nwrap = 1'b1;
                    nsat  = 1'b0;
                end else begin
                    nsat = 1'b1;
                end
            end else begin
                nb   = bin_out - 1'b1;
                nsat = 1'b0;
            end
        end
    end

    // Binary and Gray registered together from the same next value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
            sat      <= 1'b0;
        end else begin
            bin_out  <= nb;
            gray_out <= nb ^ (nb >> 1);
            wrap     <= nwrap;
            sat      <= WRAP ? 1'b0 : nsat;
        end
    end

endmodule

// File: tb/tb_gray_counter_updown.sv
// Directed bench for gray_counter_updown.
// Runs a wrapping and a saturating instance side by side on shared stimulus.
module tb_gray_counter_updown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_bin = 4'd0;

    logic [3:0] g0, b0, g1, b1;
    logic       w0, s0, w1, s1;

    int n_tests = 0;
    int n_fail  = 0;

    gray_counter_updown #(.WIDTH(4), .WRAP(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .gray_out(g0), .bin_out(b0),
        .wrap(w0), .sat(s0)
    );

    gray_counter_updown #(.WIDTH(4), .WRAP(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .gray_out(g1), .bin_out(b1),
        .wrap(w1), .sat(s1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int popc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gseq [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
        4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
    };

    logic [3:0] prev;

    initial begin
        // 1: reset dominates en and load
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_bin = 4'b0101; up = 1'b1;
        tick(); tick();
        chk("rst_gray", 32'(g0), 32'h0);
        chk("rst_bin", 32'(b0), 32'h0);
        chk("rst_wrap", 32'(w0), 32'h0);
        chk("rst_sat", 32'(s0), 32'h0);
        chk("rst_gray_w0", 32'(g1), 32'h0);
        chk("rst_sat_w0", 32'(s1), 32'h0);

        // 2: full up sequence with wrap
        rst_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prev = g0;
            tick();
            chk($sformatf("up_gray%0d", i), 32'(g0), 32'(gseq[i]));
            chk($sformatf("up_bin%0d", i), 32'(b0), 32'((i + 1) % 16));
            chk($sformatf("up_wrap%0d", i), 32'(w0), (i == 15) ? 32'h1 : 32'h0);
            chk($sformatf("up_1bit%0d", i), 32'(popc(g0 ^ prev)), 32'h1);
            chk($sformatf("up_g2b%0d", i), 32'(g2b(g0)), 32'((i + 1) % 16));
        end

        // 3: down from 0 wraps to max
        up = 1'b0;
        tick();
        chk("dn_bin", 32'(b0), 32'hF);
        chk("dn_gray", 32'(g0), 32'b1000);
        chk("dn_wrap", 32'(w0), 32'h1);
        en = 1'b0; up = 1'b1;
        prev = g0;
        tick();
        chk("hold_wrap", 32'(w0), 32'h0);
        chk("hold_gray", 32'(popc(g0 ^ prev)), 32'h0);
        chk("hold_bin", 32'(b0), 32'hF);

        // 4: load beats en
        load = 1'b1; load_bin = 4'b1010; en = 1'b1; up = 1'b1;
        tick();
        chk("ld_bin", 32'(b0), 32'b1010);
        chk("ld_gray", 32'(g0), 32'b1111);
        chk("ld_wrap", 32'(w0), 32'h0);
        tick();
        chk("ld_same_bin", 32'(b0), 32'b1010);
        chk("ld_same_gray", 32'(g0), 32'b1111);
        chk("ld_same_wrap", 32'(w0), 32'h0);

        // 5: saturating instance at the top, then step down
        load_bin = 4'b1111;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_bin%0d", i), 32'(b1), 32'hF);
            chk($sformatf("sat_gray%0d", i), 32'(g1), 32'b1000);
            chk($sformatf("sat_flag%0d", i), 32'(s1), 32'h1);
            chk($sformatf("sat_wrap%0d", i), 32'(w1), 32'h0);
        end
        chk("wrap_inst_sat", 32'(s0), 32'h0);
        up = 1'b0;
        tick();
        chk("unsat_bin", 32'(b1), 32'hE);
        chk("unsat_gray", 32'(g1), 32'b1001);
        chk("unsat_flag", 32'(s1), 32'h0);

        // saturating at the bottom, and load clears sat
        load = 1'b1; load_bin = 4'b0000;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        chk("satlo_bin", 32'(b1), 32'h0);
        chk("satlo_flag", 32'(s1), 32'h1);
        load = 1'b1; load_bin = 4'b0011;
        tick();
        chk("satlo_ld_flag", 32'(s1), 32'h0);
        chk("satlo_ld_gray", 32'(g1), 32'b0010);

        // 6: reset mid-count, then resume
        load = 1'b0; en = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_bin", 32'(b0), 32'b0110);
        chk("mid_gray", 32'(g0), 32'b0101);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gray", 32'(g0), 32'h0);
        chk("mid_rst_bin", 32'(b0), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("resume_gray", 32'(g0), 32'b0001);
        chk("resume_bin", 32'(b0), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
